pc_seq: RTL
===========

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter D, default 10: PC and branch-target width in bits.
REQ-002 Parameter N_TGT, default 16: number of branch-target table entries; the index is 4 bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  in IDLE or HALT, begin execution at PC 0.
REQ-006 stall  input  1  hold PC in RUN.
REQ-007 jump_en  input  1  absolute jump to table[jump_idx].
REQ-008 jump_idx  input  4  target table index.
REQ-009 br_en  input  1  conditional relative-branch instruction present.
REQ-010 br_taken  input  1  branch condition true.
REQ-011 br_off  input  8  signed two's-complement PC offset.
REQ-012 halt_req  input  1  stop execution.
REQ-013 cfg_we  input  1  write a table entry.
REQ-014 cfg_idx  input  4  table entry written.
REQ-015 cfg_data  input  D  value written.
REQ-016 pc  output  D  current program counter.
REQ-017 fetch_valid  output  1  pc is a fetch address this cycle.
REQ-018 done  output  1  sequencer is halted.
REQ-019 state  output  2  FSM state encoding: IDLE=0, RUN=1, HALT=2.

Function
REQ-020 The FSM SHALL have states IDLE, RUN and HALT; encoding 3 is unreachable and SHALL recover to IDLE on the next edge.
REQ-021 In IDLE: start SHALL load pc=0 and enter RUN on the next edge; otherwise pc holds.
REQ-022 In RUN, next-PC priority SHALL be: halt_req > stall > jump_en > (br_en & br_taken) > pc+1.
REQ-023 halt_req in RUN SHALL enter HALT with pc held.
REQ-024 stall in RUN SHALL hold pc and state.
REQ-025 jump_en SHALL load pc = table[jump_idx] on the next edge.
REQ-026 A taken branch SHALL load pc = (pc + sign_extend(br_off)) mod 2^D.
REQ-027 A not-taken branch SHALL increment pc by 1.
REQ-028 pc+1 SHALL wrap from 2^D-1 to 0.
REQ-029 When jump_en and br_en are both asserted, jump_en SHALL win.
REQ-030 All PC updates SHALL have one-cycle latency (registered pc, no combinational input-to-pc path).
REQ-031 fetch_valid SHALL equal (state==RUN) & ~stall, combinationally.
REQ-032 done SHALL equal (state==HALT).
REQ-033 In HALT, pc SHALL hold; start SHALL load pc=0 and enter RUN.
REQ-034 cfg_we SHALL update table[cfg_idx] only in IDLE or HALT; in RUN it SHALL be ignored.
REQ-035 A table read in the same cycle as a write to the same entry SHALL return the old value.

Reset
REQ-036 reset SHALL force state=IDLE, pc=0, fetch_valid=0 and done=0 on the next edge, including mid-RUN and mid-stall.
REQ-037 reset SHALL reload the table to entry0=0, entry1=11, entry2=41, entry3=99, entry4=72, entry5=87, and entries 6-15=0.
REQ-038 reset SHALL override every other input in the same cycle.

Structure
REQ-039 The state enum, D default, N_TGT, and the table reset-value constants SHALL live in the shared package pc_seq_pkg.
REQ-040 The target table SHALL be a sub-module, tgt_table: a writable register file with combinational read port and synchronous write port, reset-loaded.
REQ-041 The next-PC mux and the FSM SHALL reside in pc_seq.

Verification
REQ-042 Reset, then start, then 5 free cycles -> pc sequence 0,1,2,3,4,5; fetch_valid=1 throughout.
REQ-043 In RUN at pc=4, br_en=1, br_taken=1, br_off=-5 -> next pc=1023; at pc=4, br_off=+20 -> 24; br_taken=0 -> 5.
REQ-044 At pc=7, jump_en=1, jump_idx=3, br_en=1, br_taken=1 -> pc=99 (jump wins); stall=1 with jump_en=1 -> pc holds at 7, fetch_valid=0.
REQ-045 At pc=1023, no control -> pc=0; halt_req -> done=1, pc held; start -> pc=0, state RUN.
REQ-046 In IDLE, cfg_we writes idx 2 = 500, then start, jump_idx=2 -> pc=500; the same write in RUN -> ignored, jump -> 41; reset mid-RUN -> pc=0, state IDLE, table entry2=41.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer:
// FSM state encoding, default widths and the branch-target table reset image.
package pc_seq_pkg;

  localparam int D_DEF = 10;
  localparam int N_TGT = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Power-on contents of the branch-target table.
  function automatic int unsigned tgt_reset_val(input int idx);
    case (idx)
      1:       return 11;
      2:       return 41;
      3:       return 99;
      4:       return 72;
      5:       return 87;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Control/status bundle of the sequencer; master drives control, slave is the sequencer.
interface pc_seq_if
  import pc_seq_pkg::*;
#(
  parameter int D = D_DEF
);

  logic             start;
  logic             stall;
  logic             jump_en;
  logic [IDX_W-1:0] jump_idx;
  logic             br_en;
  logic             br_taken;
  logic [7:0]       br_off;
  logic             halt_req;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [D-1:0]     cfg_data;
  logic [D-1:0]     pc;
  logic             fetch_valid;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, stall, jump_en, jump_idx, br_en, br_taken, br_off, halt_req,
           cfg_we, cfg_idx, cfg_data,
    input  pc, fetch_valid, done, state
  );

  modport slave (
    input  start, stall, jump_en, jump_idx, br_en, br_taken, br_off, halt_req,
           cfg_we, cfg_idx, cfg_data,
    output pc, fetch_valid, done, state
  );

endinterface

// File: rtl/pc_seq_tgt_table.sv
// Branch-target register file: combinational read, synchronous write,
// reloaded with the package reset image on reset.
module tgt_table
  import pc_seq_pkg::*;
#(
  parameter int D = D_DEF,
  parameter int N = N_TGT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [D-1:0]     wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [D-1:0]     rdata
);

  logic [D-1:0] mem [N];

  // NOTE: this array is reset on purpose -- the table must come up with known
  // targets, so it is built from flops rather than an inferred RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= D'(tgt_reset_val(i));
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Read returns the pre-write value when reading the entry being written.
  assign rdata = mem[ridx];

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: IDLE/RUN/HALT FSM with a prioritised next-PC mux
// (halt > stall > jump > taken branch > increment) and a writable target table.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int D = D_DEF
) (
  input  logic     clk,
  input  logic     reset,
  pc_seq_if.slave  bus
);

  state_t       state_q;
  logic [D-1:0] pc_q;
  logic [D-1:0] tgt;
  logic [D-1:0] br_tgt;
  logic         cfg_ok;

  // Table may only be reprogrammed while the sequencer is not executing.
  assign cfg_ok = (state_q == ST_IDLE) || (state_q == ST_HALT);

  tgt_table #(.D(D), .N(N_TGT)) u_tgt (
    .clk   (clk),
    .reset (reset),
    .we    (bus.cfg_we && cfg_ok),
    .widx  (bus.cfg_idx),
    .wdata (bus.cfg_data),
    .ridx  (bus.jump_idx),
    .rdata (tgt)
  );

  // Sign-extend the 8-bit offset; the D-bit add wraps modulo 2^D.
  assign br_tgt = pc_q + D'($signed(bus.br_off));

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (bus.start) begin
            pc_q    <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.halt_req)                  state_q <= ST_HALT;
          else if (bus.stall)                pc_q    <= pc_q;
          else if (bus.jump_en)              pc_q    <= tgt;
          else if (bus.br_en && bus.br_taken) pc_q   <= br_tgt;
          else                               pc_q    <= pc_q + D'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.state       = state_q;
  assign bus.fetch_valid = (state_q == ST_RUN) && !bus.stall;
  assign bus.done        = (state_q == ST_HALT);

endmodule
